// File: rtl/regfile_pkg.sv
// Shared constants for the decode-stage register file: default geometry and
// symbolic MIPS register numbers.
package regfile_pkg;

  localparam int REGFILE_DW    = 32;
  localparam int REGFILE_NREGS = 32;
  localparam int REGFILE_NREAD = 2;

  localparam int REG_ZERO = 0;
  localparam int REG_AT   = 1;
  localparam int REG_V0   = 2;
  localparam int REG_V1   = 3;
  localparam int REG_A0   = 4;
  localparam int REG_A1   = 5;
  localparam int REG_A2   = 6;
  localparam int REG_A3   = 7;
  localparam int REG_T0   = 8;
  localparam int REG_S0   = 16;
  localparam int REG_T8   = 24;
  localparam int REG_K0   = 26;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;
  localparam int REG_FP   = 30;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with set-over-clear priority and a registered
// busy count. REGFILE_BYPASS_EN selects the next-state vector for busy_view.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(NREGS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  output logic [NREGS-1:0] busy_view,
  output logic [CW-1:0]    busy_cnt
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             iss_hit;
  logic             wr_hit;
  logic             set_new;
  logic             clr_old;

  assign iss_hit = iss_en && (iss_addr != '0);
  assign wr_hit  = wr_en && (wr_addr != '0);

  // A clear only counts when it actually drops a set bit and is not
  // overridden by a same-address issue.
  assign set_new = iss_hit && !busy[iss_addr];
  assign clr_old = wr_hit && busy[wr_addr] && !(iss_hit && (iss_addr == wr_addr));

  // NOTE: every variable in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_nxt = busy;
    if (wr_hit)  busy_nxt[wr_addr]  = 1'b0;
    if (iss_hit) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = busy_cnt;
    if (set_new && !clr_old)      cnt_nxt = busy_cnt + 1'b1;
    else if (clr_old && !set_new) cnt_nxt = busy_cnt - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign busy_view = busy_nxt;
`else
  assign busy_view = busy;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads and busy scoreboard.
// Defining REGFILE_BYPASS_EN forwards same-cycle writeback data and busy state.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  DW    = REGFILE_DW,
  parameter int  NREGS = REGFILE_NREGS,
  parameter int  NREAD = REGFILE_NREAD,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD*DW-1:0] rd_data,
  output logic [NREAD-1:0]    rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [CW-1:0]       busy_cnt
);

  logic [DW-1:0]    regs [NREGS];
  logic [NREGS-1:0] busy_view;
  logic             wr_hit;

  assign wr_hit = wr_en && (wr_addr != '0);

  // NOTE: the array is reset because architectural state must read zero after
  // reset; this keeps it in flops rather than a RAM macro without reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .CW    (CW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy_view (busy_view),
    .busy_cnt  (busy_cnt)
  );

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;
    logic          busy_q;

    assign addr = rd_addr[gi*AW +: AW];

    always_comb begin
      data_d = '0;
      if (addr != '0) data_d = regs[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (wr_addr == addr)) data_d = wr_data;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q <= busy_view[addr];
      end
    end

    assign rd_data[gi*DW +: DW] = data_q;
    assign rd_busy[gi]          = busy_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus random traffic against an
// array-based architectural model; honours REGFILE_BYPASS_EN.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [5:0]  busy_cnt;

  logic [11:0] s_rd_addr = '0;
  logic [95:0] s_rd_data;
  logic [2:0]  s_rd_busy;
  logic        s_wr_en = 1'b0;
  logic [3:0]  s_wr_addr = '0;
  logic [31:0] s_wr_data = '0;
  logic        s_iss_en = 1'b0;
  logic [3:0]  s_iss_addr = '0;
  logic [4:0]  s_busy_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile_mp #(.DW(32), .NREGS(32), .NREAD(2)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt)
  );

  regfile_mp #(.DW(32), .NREGS(16), .NREAD(3)) u_small (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (s_rd_addr),
    .rd_data  (s_rd_data),
    .rd_busy  (s_rd_busy),
    .wr_en    (s_wr_en),
    .wr_addr  (s_wr_addr),
    .wr_data  (s_wr_data),
    .iss_en   (s_iss_en),
    .iss_addr (s_iss_addr),
    .busy_cnt (s_busy_cnt)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // One clock: drive at the negedge, predict from the model, check after the edge.
  task automatic cycle(input bit we, input int wa, input logic [31:0] wd,
                       input bit ie, input int ia, input int ra0, input int ra1);
    logic [31:0] e_data [2];
    bit          e_busy [2];
    int          ra [2];
    @(negedge clk);
    wr_en    = we;
    wr_addr  = wa[4:0];
    wr_data  = wd;
    iss_en   = ie;
    iss_addr = ia[4:0];
    rd_addr  = {ra1[4:0], ra0[4:0]};
    ra[0] = ra0;
    ra[1] = ra1;
    for (int p = 0; p < 2; p++) begin
      e_data[p] = (ra[p] == 0) ? 32'h0 : m_regs[ra[p]];
      e_busy[p] = m_busy[ra[p]];
`ifdef REGFILE_BYPASS_EN
      if (we && wa != 0 && wa == ra[p]) e_data[p] = wd;
`endif
    end
    if (we && wa != 0) begin
      m_regs[wa] = wd;
      m_busy[wa] = 1'b0;
    end
    if (ie && ia != 0) m_busy[ia] = 1'b1;
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < 2; p++) e_busy[p] = m_busy[ra[p]];
`endif
    @(posedge clk);
    #1;
    check("rd_data0", rd_data[31:0], e_data[0]);
    check("rd_data1", rd_data[63:32], e_data[1]);
    check("rd_busy0", rd_busy[0], e_busy[0]);
    check("rd_busy1", rd_busy[1], e_busy[1]);
    check("busy_cnt", busy_cnt, model_count());
  endtask

  task automatic mid_reset();
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = 5'($urandom_range(1, 31));
    wr_data  = $urandom;
    iss_en   = 1'b1;
    iss_addr = 5'($urandom_range(1, 31));
    #2 rst = 1'b1;
    #1;
    check("rst_rd_data", rd_data, 64'h0);
    check("rst_rd_busy", rd_busy, 2'b00);
    check("rst_busy_cnt", busy_cnt, 6'd0);
    @(posedge clk);
    #1;
    check("rst_hold_cnt", busy_cnt, 6'd0);
    check("rst_hold_data", rd_data, 64'h0);
    @(negedge clk);
    rst    = 1'b0;
    wr_en  = 1'b0;
    iss_en = 1'b0;
    model_clear();
  endtask

  task automatic small_test();
    @(negedge clk);
    wr_en = 1'b0;
    iss_en = 1'b0;
    s_wr_en = 1'b1; s_wr_addr = 4'd1;  s_wr_data = 32'h1;
    s_iss_en = 1'b1; s_iss_addr = 4'd3;
    @(negedge clk);
    s_iss_en = 1'b0;
    s_wr_addr = 4'd2;  s_wr_data = 32'h2;
    @(negedge clk);
    s_wr_addr = 4'd15; s_wr_data = 32'hF;
    @(negedge clk);
    s_wr_en = 1'b0;
    s_rd_addr = {4'd15, 4'd2, 4'd1};
    @(posedge clk);
    #1;
    check("s_port0", s_rd_data[31:0], 32'h1);
    check("s_port1", s_rd_data[63:32], 32'h2);
    check("s_port2", s_rd_data[95:64], 32'hF);
    check("s_busy_cnt", s_busy_cnt, 5'd1);
    check("s_rd_busy", s_rd_busy, 3'b000);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("s_rst_data", s_rd_data, 96'h0);
    check("s_rst_cnt", s_busy_cnt, 5'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    #12 rst = 1'b0;

    // Some traffic, then an asynchronous reset in the middle of a write.
    cycle(1, 7, 32'hCAFE0007, 1, 12, 7, 12);
    cycle(1, 12, 32'h0000BEEF, 0, 0, 12, 7);
    mid_reset();
    for (int a = 0; a < 32; a += 2) cycle(0, 0, 32'h0, 0, 0, a, a + 1);

    // Register zero ignores writes and issues.
    cycle(1, 0, 32'hDEADBEEF, 1, 0, 0, 0);
    cycle(0, 0, 32'h0, 0, 0, 0, 0);
    check("r0_reads_zero", rd_data[31:0], 32'h0);
    check("r0_no_busy", busy_cnt, 6'd0);

    // Same-cycle write/read of r5.
    cycle(1, 5, 32'h12345678, 0, 0, 5, 0);
`ifdef REGFILE_BYPASS_EN
    check("r5_same_cycle", rd_data[31:0], 32'h12345678);
`else
    check("r5_same_cycle", rd_data[31:0], 32'h0);
`endif
    cycle(0, 0, 32'h0, 0, 0, 5, 0);
    check("r5_next_cycle", rd_data[31:0], 32'h12345678);

    // Issue r8, r9, then retire r8.
    cycle(0, 0, 32'h0, 1, 8, 8, 9);
    cycle(0, 0, 32'h0, 1, 9, 8, 9);
    check("cnt_two", busy_cnt, 6'd2);
    cycle(1, 8, 32'h88, 0, 0, 0, 8);
    check("cnt_one", busy_cnt, 6'd1);
    cycle(0, 0, 32'h0, 0, 0, 8, 9);
    check("r8_not_busy", rd_busy[0], 1'b0);

    // Issue and writeback hit r10 together while r10 is busy.
    cycle(0, 0, 32'h0, 1, 10, 10, 0);
    cycle(1, 10, 32'hA5A5A5A5, 1, 10, 0, 0);
    check("r10_cnt_same", busy_cnt, 6'd2);
    cycle(0, 0, 32'h0, 0, 0, 10, 0);
    check("r10_data", rd_data[31:0], 32'hA5A5A5A5);
    check("r10_busy", rd_busy[0], 1'b1);

    // Random traffic biased toward a few registers so hazards collide.
    for (int n = 0; n < 600; n++) begin
      int wa, ia, r0, r1;
      bit hot;
      hot = ($urandom_range(0, 1) == 1);
      wa = hot ? $urandom_range(0, 5) : $urandom_range(0, 31);
      ia = hot ? $urandom_range(0, 5) : $urandom_range(0, 31);
      r0 = hot ? $urandom_range(0, 5) : $urandom_range(0, 31);
      r1 = $urandom_range(0, 31);
      if ($urandom_range(0, 99) == 0) mid_reset();
      cycle(bit'($urandom_range(0, 1)), wa, $urandom, bit'($urandom_range(0, 1)), ia, r0, r1);
    end

    small_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
